// File: rtl/ttfir_stim_gen.sv
// On-chip stimulus source for the FIR x_in bus: plays a latched burst
// (impulse/step/alternating/PRBS), flushes with N_TAPS zeros, then pulses done.
module ttfir_stim_gen #(
  parameter int          BW_in  = 6,
  parameter int          N_TAPS = 6,
  parameter int          LEN_W  = 8,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic signed [BW_in-1:0] amp,
  input  logic [LEN_W-1:0]        len,
  output logic signed [BW_in-1:0] x_out,
  output logic                    x_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int FLW = $clog2(N_TAPS + 1);
  localparam int CW  = (LEN_W > FLW) ? LEN_W : FLW;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic signed [BW_in-1:0] AMP_MIN = {1'b1, {(BW_in-1){1'b0}}};
  localparam logic signed [BW_in-1:0] AMP_MAX = {1'b0, {(BW_in-1){1'b1}}};
  localparam logic [CW-1:0]           FLUSH_LAST = CW'(N_TAPS - 1);

  // Negation that maps the most negative code onto the most positive one.
  function automatic logic signed [BW_in-1:0] neg_sat(input logic signed [BW_in-1:0] a);
    if (a == AMP_MIN) begin
      neg_sat = AMP_MAX;
    end else begin
      neg_sat = -a;
    end
  endfunction

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  logic [1:0]              state_r, state_s;
  logic [CW-1:0]           cnt_r, cnt_s;
  logic [15:0]             lfsr_r, lfsr_s;
  logic [1:0]              mode_r, mode_s;
  logic signed [BW_in-1:0] amp_r, amp_s;
  logic [LEN_W-1:0]        len_r, len_s;
  logic signed [BW_in-1:0] sample_s, x_s;
  logic                    valid_s, busy_s, done_s;
  logic [CW-1:0]           len_last_s;

  assign len_last_s = CW'(len_r) - CW'(1);

  // Burst sample for the current run index, from the latched mode/amp.
  always_comb begin
    sample_s = {BW_in{1'b0}};
    case (mode_r)
      2'd0: begin
        if (cnt_r == {CW{1'b0}}) begin
          sample_s = amp_r;
        end else begin
          sample_s = {BW_in{1'b0}};
        end
      end
      2'd1: sample_s = amp_r;
      2'd2: begin
        if (cnt_r[0]) begin
          sample_s = neg_sat(amp_r);
        end else begin
          sample_s = amp_r;
        end
      end
      2'd3: sample_s = lfsr_r[BW_in-1:0];
      default: sample_s = {BW_in{1'b0}};
    endcase
  end

  // Next state; the state register holds what the next edge will emit,
  // so busy tracks x_valid and done follows the last flush sample.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    lfsr_s  = lfsr_r;
    mode_s  = mode_r;
    amp_s   = amp_r;
    len_s   = len_r;
    x_s     = {BW_in{1'b0}};
    valid_s = 1'b0;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          mode_s = mode;
          amp_s  = amp;
          len_s  = len;
          lfsr_s = SEED;
          cnt_s  = {CW{1'b0}};
          if (len == {LEN_W{1'b0}}) begin
            state_s = FLUSH;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        x_s     = sample_s;
        valid_s = 1'b1;
        busy_s  = 1'b1;
        lfsr_s  = lfsr_step(lfsr_r);
        if (cnt_r == len_last_s) begin
          cnt_s   = {CW{1'b0}};
          state_s = FLUSH;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      FLUSH: begin
        valid_s = 1'b1;
        busy_s  = 1'b1;
        if (cnt_r == FLUSH_LAST) begin
          cnt_s   = {CW{1'b0}};
          state_s = DONE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      DONE: begin
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State and registered outputs; rst clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      lfsr_r  <= SEED;
      mode_r  <= 2'd0;
      amp_r   <= {BW_in{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      x_out   <= {BW_in{1'b0}};
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      lfsr_r  <= lfsr_s;
      mode_r  <= mode_s;
      amp_r   <= amp_s;
      len_r   <= len_s;
      x_out   <= x_s;
      x_valid <= valid_s;
      busy    <= busy_s;
      done    <= done_s;
    end
  end

endmodule
